// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    // Controller operating state
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    // Architectural zero register (XZR): writes to it never create a dependency
    localparam int unsigned ZERO_REG = 31;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the
// instruction in ID.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             v_id_i,
    input  logic             v_ex_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic [REG_W-1:0] id_rn_i,
    input  logic [REG_W-1:0] id_rm_i,
    input  logic             id_use_rn_i,
    input  logic             id_use_rm_i,
    output logic             hazard_o
);

    logic rd_live;
    logic src_match;

    assign rd_live   = ex_rd_i != REG_W'(ZERO_REG);
    assign src_match = (id_use_rn_i & (id_rn_i == ex_rd_i)) |
                       (id_use_rm_i & (id_rm_i == ex_rd_i));
    assign hazard_o  = v_id_i & v_ex_i & ex_mem_read_i & rd_live & src_match;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage LEGv8 pipeline: bank enables,
// IF/ID flush, ID/EX bubble, stage valid bits and a data-memory watchdog.
// Optional performance counters: define PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [REG_W-1:0] id_rn_i,
    input  logic [REG_W-1:0] id_rm_i,
    input  logic             id_use_rn_i,
    input  logic             id_use_rm_i,
    input  logic             id_branch_taken_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_en_o,
    output logic             ifid_en_o,
    output logic             idex_en_o,
    output logic             exmem_en_o,
    output logic             memwb_en_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             v_id_o,
    output logic             v_ex_o,
    output logic             v_mem_o,
    output logic             v_wb_o,
    output logic             mem_error_o,
    output logic [31:0]      stall_cycles_o,
    output logic [31:0]      flush_count_o
);

    localparam int WD_W = $clog2(MEM_TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            mem_error_q, mem_error_d;
    logic            v_id_q, v_ex_q, v_mem_q, v_wb_q;
    logic            hazard, freeze, wd_expire;

    load_use_detect #(.REG_W(REG_W)) u_lud (
        .v_id_i        (v_id_q),
        .v_ex_i        (v_ex_q),
        .ex_mem_read_i (ex_mem_read_i),
        .ex_rd_i       (ex_rd_i),
        .id_rn_i       (id_rn_i),
        .id_rm_i       (id_rm_i),
        .id_use_rn_i   (id_use_rn_i),
        .id_use_rm_i   (id_use_rm_i),
        .hazard_o      (hazard)
    );

    // A pending data access freezes the whole pipe until the memory answers
    assign freeze = ((state_q == RUN) & v_mem_q & mem_req_i & ~mem_ready_i) |
                    ((state_q == MEM_WAIT) & ~mem_ready_i);

    // wd_q counts completed MEM_WAIT cycles, so the MEM_TIMEOUT-th wait cycle
    // sees MEM_TIMEOUT-1; a late mem_ready on that cycle still completes.
    assign wd_expire = (state_q == MEM_WAIT) & ~mem_ready_i &
                       (wd_q == WD_W'(MEM_TIMEOUT - 1));

    // State, watchdog and sticky error registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            wd_q        <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            mem_error_q <= mem_error_d;
        end
    end

    // Next-state: enter MEM_WAIT on a stalled access, leave on ready or watchdog
    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        mem_error_d = mem_error_q;
        case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d = MEM_WAIT;
                    wd_d    = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ready_i) begin
                    state_d = RUN;
                end else if (wd_expire) begin
                    state_d     = HALT;
                    mem_error_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    // Outputs: reset > halt > freeze > load-use > taken branch > advance
    always_comb begin
        pc_en_o       = 1'b0;
        ifid_en_o     = 1'b0;
        idex_en_o     = 1'b0;
        exmem_en_o    = 1'b0;
        memwb_en_o    = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        if (!rst_ni) begin
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (state_q != HALT && !freeze) begin
            idex_en_o  = 1'b1;
            exmem_en_o = 1'b1;
            memwb_en_o = 1'b1;
            if (hazard) begin
                idex_bubble_o = 1'b1;
            end else begin
                pc_en_o      = 1'b1;
                ifid_en_o    = 1'b1;
                ifid_flush_o = v_id_q & id_branch_taken_i;
            end
        end
    end

    // Valid bits follow their bank: only move when the receiving bank loads
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_id_q  <= 1'b0;
            v_ex_q  <= 1'b0;
            v_mem_q <= 1'b0;
            v_wb_q  <= 1'b0;
        end else begin
            if (ifid_en_o)  v_id_q  <= ~ifid_flush_o;
            if (idex_en_o)  v_ex_q  <= v_id_q & ~idex_bubble_o;
            if (exmem_en_o) v_mem_q <= v_ex_q;
            if (memwb_en_o) v_wb_q  <= v_mem_q;
        end
    end

    assign v_id_o      = v_id_q;
    assign v_ex_o      = v_ex_q;
    assign v_mem_o     = v_mem_q;
    assign v_wb_o      = v_wb_q;
    assign mem_error_o = mem_error_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_q, flush_q;

    // Count front-end stall cycles and IF/ID squashes; both wrap naturally
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en_o || !ifid_en_o) stall_q <= stall_q + 32'd1;
            if (ifid_flush_o)           flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_count_o  = flush_q;
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif

endmodule
